// File: rtl/game_ctrl.sv
// Two-player Tetris game-flow sequencer: IDLE/RUN/PAUSE/OVER FSM, ms tick, round timer,
// per-player gravity and level tracking, winner latch. Optional soft drop: GAME_CTRL_SOFTDROP_EN.
module game_ctrl #(
  parameter int TICK_DIV        = 100000,
  parameter int BASE_DROP_MS    = 800,
  parameter int STEP_MS         = 60,
  parameter int MIN_DROP_MS     = 100,
  parameter int MAX_LEVEL       = 15,
  parameter int LINES_PER_LEVEL = 10,
  parameter int GAME_SECONDS    = 180
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       start_key,
  input  logic       pause_key,
  input  logic       over1,
  input  logic       over2,
  input  logic       clr1_vld,
  input  logic       clr2_vld,
  input  logic [2:0] clr1_cnt,
  input  logic [2:0] clr2_cnt,
`ifdef GAME_CTRL_SOFTDROP_EN
  input  logic       soft1,
  input  logic       soft2,
`endif
  output logic [1:0] state,
  output logic       run,
  output logic       drop1,
  output logic       drop2,
  output logic [3:0] level1,
  output logic [3:0] level2,
  output logic [9:0] lines1,
  output logic [9:0] lines2,
  output logic [7:0] time_left,
  output logic [1:0] winner
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = $clog2(LINES_PER_LEVEL + 4);
  localparam int DW = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;

  typedef struct packed {
    logic [9:0]    lines;
    logic [SW-1:0] sub;
    logic [3:0]    level;
  } acct_t;

  state_t        state_q, state_d;
  logic          start_go, in_run, tick, to_over;
  logic [PW-1:0] presc;
  logic [9:0]    ms_cnt;
  logic [DW-1:0] dcnt1, dcnt2, iv1, iv2;
  logic          fire1, fire2;
  acct_t         acc1, acc2, acc1_d, acc2_d;

  // Signed so that high levels clamp to the floor instead of wrapping.
  function automatic logic [DW-1:0] drop_interval(input logic [3:0] lvl);
    int iv;
    iv = BASE_DROP_MS - int'(lvl) * STEP_MS;
    if (iv < MIN_DROP_MS) iv = MIN_DROP_MS;
    return DW'(iv);
  endfunction

  function automatic acct_t account(input acct_t cur, input logic [2:0] cnt);
    acct_t nxt;
    int    l;
    int    s;
    nxt = cur;
    if (cnt != 3'd0 && cnt <= 3'd4) begin
      l         = int'(cur.lines) + int'(cnt);
      nxt.lines = (l > 1023) ? 10'd1023 : 10'(l);
      s         = int'(cur.sub) + int'(cnt);
      if (s >= LINES_PER_LEVEL) begin
        s = s - LINES_PER_LEVEL;
        if (int'(cur.level) < MAX_LEVEL) nxt.level = cur.level + 4'd1;
      end
      nxt.sub = SW'(s);
    end
    return nxt;
  endfunction

  assign in_run = (state_q == RUN);
  assign tick   = in_run && (presc == PW'(TICK_DIV - 1));

`ifdef GAME_CTRL_SOFTDROP_EN
  assign iv1 = soft1 ? DW'(MIN_DROP_MS) : drop_interval(acc1.level);
  assign iv2 = soft2 ? DW'(MIN_DROP_MS) : drop_interval(acc2.level);
`else
  assign iv1 = drop_interval(acc1.level);
  assign iv2 = drop_interval(acc2.level);
`endif

  // ">=" lets a counter that overshot a freshly shortened interval fire on the next tick.
  assign fire1 = tick && (dcnt1 >= iv1 - DW'(1));
  assign fire2 = tick && (dcnt2 >= iv2 - DW'(1));

  always_comb begin
    acc1_d = acc1;
    acc2_d = acc2;
    if (in_run && clr1_vld) acc1_d = account(acc1, clr1_cnt);
    if (in_run && clr2_vld) acc2_d = account(acc2, clr2_cnt);
  end

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_key) begin
          state_d  = RUN;
          start_go = 1'b1;
        end
      end
      RUN: begin
        if (over1 || over2 || time_left == 8'd0) state_d = OVER;
        else if (pause_key)                      state_d = PAUSE;
      end
      PAUSE: begin
        if (pause_key || start_key) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
    to_over = in_run && (state_d == OVER);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      run     <= 1'b0;
    end else begin
      state_q <= state_d;
      run     <= (state_d == RUN);
    end
  end

  assign state  = state_q;
  assign level1 = acc1.level;
  assign level2 = acc2.level;
  assign lines1 = acc1.lines;
  assign lines2 = acc2.lines;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      presc     <= '0;
      ms_cnt    <= '0;
      time_left <= 8'(GAME_SECONDS);
      dcnt1     <= '0;
      dcnt2     <= '0;
      drop1     <= 1'b0;
      drop2     <= 1'b0;
      acc1      <= '0;
      acc2      <= '0;
      winner    <= 2'b00;
    end else if (start_go) begin
      presc     <= '0;
      ms_cnt    <= '0;
      time_left <= 8'(GAME_SECONDS);
      dcnt1     <= '0;
      dcnt2     <= '0;
      drop1     <= 1'b0;
      drop2     <= 1'b0;
      acc1      <= '0;
      acc2      <= '0;
      winner    <= 2'b00;
    end else begin
      // A pulse due on the cycle we leave RUN is suppressed so PAUSE/OVER never show a drop.
      drop1 <= fire1 && (state_d == RUN);
      drop2 <= fire2 && (state_d == RUN);
      acc1  <= acc1_d;
      acc2  <= acc2_d;
      if (in_run) presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        ms_cnt <= (ms_cnt == 10'd999) ? '0 : ms_cnt + 10'd1;
        if (ms_cnt == 10'd999 && time_left != 8'd0) time_left <= time_left - 8'd1;
        dcnt1 <= fire1 ? '0 : dcnt1 + DW'(1);
        dcnt2 <= fire2 ? '0 : dcnt2 + DW'(1);
      end
      if (to_over) begin
        if (over1 && over2)                      winner <= 2'b11;
        else if (over1)                          winner <= 2'b10;
        else if (over2)                          winner <= 2'b01;
        else if (acc1_d.lines > acc2_d.lines)    winner <= 2'b01;
        else if (acc1_d.lines < acc2_d.lines)    winner <= 2'b10;
        else                                     winner <= 2'b11;
      end
    end
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed testbench for game_ctrl: gravity timing, levels, pause, game over, winner and timeout.
module tb_game_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_key, pause_key, over1, over2, clr1_vld, clr2_vld;
  logic [2:0] clr1_cnt, clr2_cnt;
  logic [1:0] state, winner;
  logic       run, drop1, drop2;
  logic [3:0] level1, level2;
  logic [9:0] lines1, lines2;
  logic [7:0] time_left;

  logic       t_start, t_clr1_vld, t_clr2_vld;
  logic [2:0] t_clr1_cnt, t_clr2_cnt;
  logic [1:0] t_state, t_winner;
  logic       t_run, t_drop1, t_drop2;
  logic [3:0] t_level1, t_level2;
  logic [9:0] t_lines1, t_lines2;
  logic [7:0] t_time_left;

  int cyc = 0;
  int checks_total = 0;
  int checks_passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_ctrl #(.TICK_DIV(10)) dut (
    .clk(clk), .rstn(rstn), .start_key(start_key), .pause_key(pause_key),
    .over1(over1), .over2(over2), .clr1_vld(clr1_vld), .clr2_vld(clr2_vld),
    .clr1_cnt(clr1_cnt), .clr2_cnt(clr2_cnt),
`ifdef GAME_CTRL_SOFTDROP_EN
    .soft1(1'b0), .soft2(1'b0),
`endif
    .state(state), .run(run), .drop1(drop1), .drop2(drop2),
    .level1(level1), .level2(level2), .lines1(lines1), .lines2(lines2),
    .time_left(time_left), .winner(winner)
  );

  game_ctrl #(.TICK_DIV(2), .GAME_SECONDS(2)) dut_t (
    .clk(clk), .rstn(rstn), .start_key(t_start), .pause_key(1'b0),
    .over1(1'b0), .over2(1'b0), .clr1_vld(t_clr1_vld), .clr2_vld(t_clr2_vld),
    .clr1_cnt(t_clr1_cnt), .clr2_cnt(t_clr2_cnt),
`ifdef GAME_CTRL_SOFTDROP_EN
    .soft1(1'b0), .soft2(1'b0),
`endif
    .state(t_state), .run(t_run), .drop1(t_drop1), .drop2(t_drop2),
    .level1(t_level1), .level2(t_level2), .lines1(t_lines1), .lines2(t_lines2),
    .time_left(t_time_left), .winner(t_winner)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    else
      checks_passed++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of key/clear pulses on the main instance, then releases them.
  task automatic applyStimulus(input logic st, input logic pk, input logic c1v, input logic [2:0] c1c,
                               input logic c2v, input logic [2:0] c2c);
    start_key = st;  pause_key = pk;
    clr1_vld  = c1v; clr1_cnt  = c1c;
    clr2_vld  = c2v; clr2_cnt  = c2c;
    step();
    start_key = 1'b0; pause_key = 1'b0;
    clr1_vld  = 1'b0; clr2_vld  = 1'b0;
    clr1_cnt  = 3'd0; clr2_cnt  = 3'd0;
  endtask

  task automatic waitDrop(input string tag, input int which, input int limit, output int stamp);
    logic seen;
    seen  = 1'b0;
    stamp = -1;
    for (int i = 0; i < limit && !seen; i++) begin
      step();
      if ((which == 1 && drop1 === 1'b1) || (which == 2 && drop2 === 1'b1)) begin
        seen  = 1'b1;
        stamp = cyc;
      end
    end
    checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
  endtask

  int t0, p, s, s1, s2, s3, a, b, d2, r, tl, bad_state, any_drop, tb0;

  initial begin
    rstn = 1'b0;
    start_key = 0; pause_key = 0; over1 = 0; over2 = 0;
    clr1_vld = 0; clr2_vld = 0; clr1_cnt = 0; clr2_cnt = 0;
    t_start = 0; t_clr1_vld = 0; t_clr2_vld = 0; t_clr1_cnt = 0; t_clr2_cnt = 0;
    repeat (3) step();
    checkOutput("rst_state", 32'(state), 32'd0);
    checkOutput("rst_run", 32'(run), 32'd0);
    checkOutput("rst_drop1", 32'(drop1), 32'd0);
    checkOutput("rst_level1", 32'(level1), 32'd0);
    checkOutput("rst_lines2", 32'(lines2), 32'd0);
    checkOutput("rst_time_left", 32'(time_left), 32'd180);
    checkOutput("rst_winner", 32'(winner), 32'd0);
    checkOutput("rst_t_time_left", 32'(t_time_left), 32'd2);
    rstn = 1'b1;
    step();

    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("idle_ignores_pause", 32'(state), 32'd0);

    // Start: RUN next cycle, first drops 800 ticks * 10 cycles later.
    applyStimulus(1, 0, 0, 0, 0, 0);
    t0 = cyc;
    checkOutput("start_state", 32'(state), 32'd1);
    checkOutput("start_run", 32'(run), 32'd1);
    waitDrop("first_drop1", 1, 8100, s);
    checkOutput("first_drop1_delay", s - t0, 32'd8000);
    checkOutput("first_drop2_same", 32'(drop2), 32'd1);
    p = s;
    step();
    checkOutput("drop1_width", 32'(drop1), 32'd0);

    // Three 4-line clears: 12 lines, level 1, interval 740 ms.
    repeat (3) applyStimulus(0, 0, 1, 3'd4, 0, 0);
    checkOutput("lines1_12", 32'(lines1), 32'd12);
    checkOutput("level1_1", 32'(level1), 32'd1);
    checkOutput("level2_0", 32'(level2), 32'd0);
    applyStimulus(0, 0, 1, 3'd0, 0, 0);
    applyStimulus(0, 0, 1, 3'd5, 0, 0);
    checkOutput("bad_cnt_ignored", 32'(lines1), 32'd12);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("run_ignores_start", 32'(state), 32'd1);
    waitDrop("lvl1_drop1", 1, 8100, s1);
    checkOutput("lvl1_first_period", s1 - p, 32'd7400);
    waitDrop("lvl0_drop2", 2, 1000, s2);
    checkOutput("drop2_period", s2 - p, 32'd8000);
    waitDrop("lvl1_drop1b", 1, 7500, s3);
    checkOutput("lvl1_period", s3 - s1, 32'd7400);

    // 40 more 4-line clears: 172 lines, level saturates, interval clamps to 100 ms.
    repeat (40) applyStimulus(0, 0, 1, 3'd4, 0, 0);
    checkOutput("level1_sat", 32'(level1), 32'd15);
    checkOutput("lines1_172", 32'(lines1), 32'd172);
    waitDrop("fast_a", 1, 1100, a);
    waitDrop("fast_b", 1, 1100, b);
    checkOutput("min_period", b - a, 32'd1000);
    checkOutput("level2_still_0", 32'(level2), 32'd0);

    // Pause 3000 cycles after a drop2, hold 5000 cycles, resume: 500 ticks still owed.
    waitDrop("pause_ref", 2, 8100, d2);
    repeat (2999) step();
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("pause_state", 32'(state), 32'd2);
    checkOutput("pause_run", 32'(run), 32'd0);
    tl = int'(time_left);
    bad_state = 0;
    any_drop  = 0;
    repeat (4999) begin
      step();
      if (state !== 2'd2) bad_state++;
      if (drop1 !== 1'b0 || drop2 !== 1'b0) any_drop++;
    end
    checkOutput("pause_hold_state", bad_state, 32'd0);
    checkOutput("pause_no_drops", any_drop, 32'd0);
    checkOutput("pause_time_frozen", 32'(time_left), tl);
    applyStimulus(0, 1, 0, 0, 0, 0);
    r = cyc;
    checkOutput("resume_state", 32'(state), 32'd1);
    waitDrop("resume_drop2", 2, 5100, s);
    checkOutput("resume_drop2_delay", s - r, 32'd5000);

    applyStimulus(1, 1, 0, 0, 0, 0);
    checkOutput("pause_beats_start", 32'(state), 32'd2);
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("start_resumes", 32'(state), 32'd1);

    // over2 with pause_key: end condition wins, P1 is the winner.
    over2 = 1'b1;
    applyStimulus(0, 1, 0, 0, 0, 0);
    checkOutput("over2_state", 32'(state), 32'd3);
    checkOutput("over2_winner", 32'(winner), 32'd1);
    applyStimulus(0, 0, 1, 3'd4, 0, 0);
    checkOutput("over_lines_frozen", 32'(lines1), 32'd172);
    over2 = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("restart_state", 32'(state), 32'd1);
    checkOutput("restart_lines1", 32'(lines1), 32'd0);
    checkOutput("restart_level1", 32'(level1), 32'd0);
    checkOutput("restart_time_left", 32'(time_left), 32'd180);
    checkOutput("restart_winner", 32'(winner), 32'd0);

    over1 = 1'b1;
    applyStimulus(0, 0, 1, 3'd3, 0, 0);
    checkOutput("clr_over_state", 32'(state), 32'd3);
    checkOutput("clr_over_lines1", 32'(lines1), 32'd3);
    checkOutput("over1_winner", 32'(winner), 32'd2);
    over1 = 1'b0;
    applyStimulus(1, 0, 0, 0, 0, 0);
    over1 = 1'b1; over2 = 1'b1;
    step();
    checkOutput("both_over_winner", 32'(winner), 32'd3);
    over1 = 1'b0; over2 = 1'b0;

    // Timeout instance: 2 s at 2 cycles per ms, equal lines gives a draw.
    t_start = 1'b1; step(); t_start = 1'b0;
    tb0 = cyc;
    t_clr1_vld = 1'b1; t_clr1_cnt = 3'd2; t_clr2_vld = 1'b1; t_clr2_cnt = 3'd2;
    step();
    t_clr1_vld = 1'b0; t_clr2_vld = 1'b0;
    while (cyc < tb0 + 3990) step();
    checkOutput("t_before_state", 32'(t_state), 32'd1);
    checkOutput("t_before_time", 32'(t_time_left), 32'd1);
    while (cyc < tb0 + 4002) step();
    checkOutput("t_timeout_time", 32'(t_time_left), 32'd0);
    checkOutput("t_timeout_state", 32'(t_state), 32'd3);
    checkOutput("t_draw_winner", 32'(t_winner), 32'd3);

    t_start = 1'b1; step(); t_start = 1'b0;
    tb0 = cyc;
    checkOutput("t_restart_lines1", 32'(t_lines1), 32'd0);
    t_clr1_vld = 1'b1; t_clr1_cnt = 3'd3; t_clr2_vld = 1'b1; t_clr2_cnt = 3'd1;
    step();
    t_clr1_vld = 1'b0; t_clr2_vld = 1'b0;
    while (cyc < tb0 + 4002) step();
    checkOutput("t_p1_wins", 32'(t_winner), 32'd1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
